// File: rtl/force_release_pipe_array.sv
// Array of independent registered delay pipes with per-channel edge-triggered force/release
// overrides, a global release, and a saturating count of accepted force events.
module force_release_pipe_array #(
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 1,
    parameter int DEPTH      = 8,
    parameter int FORCE_MODE = 0,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*DATA_W-1:0]   i_a,
    input  logic [NUM_CH-1:0]          en,
    input  logic [NUM_CH*DATA_W-1:0]   force_val,
    input  logic                       release_all,
    output logic [NUM_CH*DATA_W-1:0]   o_a,
    output logic [NUM_CH-1:0]          force_active,
    output logic [CNT_W-1:0]           force_cnt
);

    localparam int POP_W = $clog2(NUM_CH + 1);
    localparam int EXT_W = CNT_W + POP_W;

    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] forced_q;
    logic [NUM_CH-1:0] forced_d;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] accept;
    logic [CNT_W-1:0]  force_cnt_q;
    logic [CNT_W-1:0]  force_cnt_d;
    logic [POP_W-1:0]  pop;
    logic [EXT_W-1:0]  cnt_sum;

    assign rise   = en & ~en_q;
    assign fall   = ~en & en_q;
    // release_all masks a coincident rise, so that edge is lost rather than deferred
    assign accept = rise & ~{NUM_CH{release_all}};

    always_comb begin
        forced_d = forced_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (release_all || fall[c]) begin
                forced_d[c] = 1'b0;
            end else if (rise[c]) begin
                forced_d[c] = 1'b1;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pop = pop + POP_W'(accept[c]);
        end
        cnt_sum = EXT_W'(force_cnt_q) + EXT_W'(pop);
        if (|cnt_sum[EXT_W-1:CNT_W]) begin
            force_cnt_d = '1;
        end else begin
            force_cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= '0;
            forced_q    <= '0;
            force_cnt_q <= '0;
        end else begin
            en_q        <= en;
            forced_q    <= forced_d;
            force_cnt_q <= force_cnt_d;
        end
    end

    assign force_active = forced_q;
    assign force_cnt    = force_cnt_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DATA_W-1:0] fval_q;
        logic [DATA_W-1:0] stage_q [DEPTH];
        logic [DATA_W-1:0] in0;
        logic [DATA_W-1:0] pipe_out;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fval_q <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    stage_q[k] <= '0;
                end
            end else begin
                if (accept[gi]) begin
                    fval_q <= force_val[gi*DATA_W +: DATA_W];
                end
                stage_q[0] <= in0;
                for (int k = 1; k < DEPTH; k++) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end
        end

        assign pipe_out = stage_q[DEPTH-1];

        // Mode 1 injects the override at the head so it travels the pipe; mode 0 muxes the tail
        if (FORCE_MODE == 1) begin : g_in_force
            assign in0                       = forced_q[gi] ? fval_q : i_a[gi*DATA_W +: DATA_W];
            assign o_a[gi*DATA_W +: DATA_W]  = pipe_out;
        end else begin : g_out_force
            assign in0                       = i_a[gi*DATA_W +: DATA_W];
            assign o_a[gi*DATA_W +: DATA_W]  = forced_q[gi] ? fval_q : pipe_out;
        end
    end

endmodule
